// File: rtl/vid_4ppc_tx.sv
// vid_4ppc_tx - 4-pixel-per-clock video test-pattern transmitter.
//
// Generates hsync/vsync/pixel_valid/data_type timing and 64-bit pixel words
// (4 lanes x 16 bit, lane 0 = leftmost pixel at bits [15:0]) for a 4PPC sink.
//
// Ports:
//   i_clk          pixel clock
//   i_rstn         asynchronous active-low reset
//   i_init_done    run enable; 0 holds the counters at 0 and the outputs low
//   i_pattern_sel  0 ramp, 1 coordinate, 2 solid (frame count), 3 checker 16x16
//   o_hsync        active-high hsync (every line, including blanking lines)
//   o_vsync        active-high vsync (whole lines)
//   o_pixel_data   four pixels, zero outside the active window
//   o_pixel_valid  active word strobe
//   o_data_type    DATA_TYPE while valid, else 0
//   o_frame_cnt    completed frame count, wraps at all-ones
//
// All outputs are registered, one clock behind the h/v counter state.
module vid_4ppc_tx #(
    parameter int          HACT      = 1920,
    parameter int          VACT      = 1080,
    parameter int          HSA       = 4,
    parameter int          HBP       = 4,
    parameter int          HFP       = 4,
    parameter int          VSA       = 1,
    parameter int          VBP       = 1,
    parameter int          VFP       = 1,
    parameter int          PPC       = 4,
    parameter int          BPP       = 16,
    parameter logic [5:0]  DATA_TYPE = 6'h1E,
    parameter int          FCNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_init_done,
    input  logic [1:0]        i_pattern_sel,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic [63:0]       o_pixel_data,
    output logic              o_pixel_valid,
    output logic [5:0]        o_data_type,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    localparam int HW   = HACT / PPC;
    localparam int HTOT = HSA + HBP + HW + HFP;
    localparam int VTOT = VSA + VBP + VACT + VFP;
    localparam int HCW  = $clog2(HTOT);
    localparam int VCW  = $clog2(VTOT);

    localparam logic [HCW-1:0] H_LAST    = HCW'(HTOT - 1);
    localparam logic [HCW-1:0] H_SA_END  = HCW'(HSA);
    localparam logic [HCW-1:0] H_ACT_BEG = HCW'(HSA + HBP);
    localparam logic [HCW-1:0] H_ACT_END = HCW'(HSA + HBP + HW);
    localparam logic [VCW-1:0] V_LAST    = VCW'(VTOT - 1);
    localparam logic [VCW-1:0] V_SA_END  = VCW'(VSA);
    localparam logic [VCW-1:0] V_ACT_BEG = VCW'(VSA + VBP);
    localparam logic [VCW-1:0] V_ACT_END = VCW'(VSA + VBP + VACT);

    logic [HCW-1:0]    h_cnt_q, h_cnt_d;
    logic [VCW-1:0]    v_cnt_q, v_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]        pat_q, pat_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              valid_q, valid_d;
    logic [63:0]       data_q, data_d;
    logic [5:0]        dtype_q, dtype_d;

    logic              act_c;
    logic [15:0]       x_w;
    logic [7:0]        y_w;
    logic [63:0]       pix_word;

    assign act_c = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END) &&
                   (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign x_w   = 16'(h_cnt_q - H_ACT_BEG);
    assign y_w   = 8'(v_cnt_q - V_ACT_BEG);

    // Pattern generator; x_w/y_w are only meaningful inside the active window.
    always_comb begin
        logic [15:0] px;
        logic [15:0] pix;
        pix_word = '0;
        for (int unsigned i = 0; i < PPC; i++) begin
            px = (x_w << 2) + 16'(i);
            case (pat_q)
                2'd0:    pix = px;
                2'd1:    pix = {y_w, px[7:0]};
                2'd2:    pix = 16'(frame_cnt_q);
                default: pix = (px[4] ^ y_w[4]) ? '1 : '0;
            endcase
            pix_word[BPP*i +: BPP] = pix;
        end
    end

    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        hsync_d     = 1'b0;
        vsync_d     = 1'b0;
        valid_d     = 1'b0;
        data_d      = '0;
        dtype_d     = '0;
        if (!i_init_done) begin
            // Idle abandons any partial frame; frame count is kept.
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else begin
            hsync_d = (h_cnt_q < H_SA_END);
            vsync_d = (v_cnt_q < V_SA_END);
            valid_d = act_c;
            data_d  = act_c ? pix_word : '0;
            dtype_d = act_c ? DATA_TYPE : '0;
            if (h_cnt_q == '0 && v_cnt_q == '0) begin
                pat_d = i_pattern_sel;
            end
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d     = '0;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end else begin
                    v_cnt_d = v_cnt_q + VCW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + HCW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            pat_q       <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            dtype_q     <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            dtype_q     <= dtype_d;
        end
    end

    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_pixel_valid = valid_q;
    assign o_pixel_data  = data_q;
    assign o_data_type   = dtype_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vid_4ppc_tx.sv
// tb_vid_4ppc_tx - self-checking bench for vid_4ppc_tx.
// Configuration: HACT=32 (8 words/line), VACT=2, default porches,
// FCNT_W=2 -> HTOT=20, VTOT=5, 100 clocks per frame.
// Active clocks h in [8,16), active lines v in {2,3}.
module tb_vid_4ppc_tx;
    localparam int HTOT  = 20;
    localparam int VTOT  = 5;
    localparam int FRAME = HTOT * VTOT;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        hsync, vsync, valid;
    logic [63:0] data;
    logic [5:0]  dtype;
    logic [1:0]  fcnt;

    int checks = 0;
    int failures = 0;

    // Reference timing model state (value before the next clock edge).
    int         mh = 0, mv = 0, mfc = 0;
    logic [1:0] mpat = 2'd0;

    vid_4ppc_tx #(
        .HACT(32),
        .VACT(2),
        .FCNT_W(2)
    ) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .i_init_done(en),
        .i_pattern_sel(sel),
        .o_hsync(hsync),
        .o_vsync(vsync),
        .o_pixel_data(data),
        .o_pixel_valid(valid),
        .o_data_type(dtype),
        .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_word(input int h, input int v,
                                               input logic [1:0] pat, input int fc);
        logic [63:0] w;
        logic [15:0] px, p, yy;
        w  = '0;
        yy = 16'(v - 2);
        for (int i = 0; i < 4; i++) begin
            px = 16'(4 * (h - 8) + i);
            case (pat)
                2'd0:    p = px;
                2'd1:    p = {yy[7:0], px[7:0]};
                2'd2:    p = 16'(fc);
                default: p = (px[4] ^ yy[4]) ? 16'hFFFF : 16'h0000;
            endcase
            w[16*i +: 16] = p;
        end
        return w;
    endfunction

    // One clock: predict outputs from the pre-edge model state, advance the
    // model, then compare all outputs 1 time unit after the edge.
    task automatic tick();
        logic        e_hs, e_vs, e_val;
        logic [63:0] e_d;
        e_hs = 1'b0; e_vs = 1'b0; e_val = 1'b0; e_d = '0;
        if (en) begin
            e_hs  = (mh < 4);
            e_vs  = (mv < 1);
            e_val = (mh >= 8) && (mh < 16) && (mv >= 2) && (mv < 4);
            e_d   = e_val ? model_word(mh, mv, mpat, mfc) : 64'h0;
            if (mh == 0 && mv == 0) mpat = sel;
            if (mh == HTOT - 1) begin
                mh = 0;
                if (mv == VTOT - 1) begin
                    mv  = 0;
                    mfc = (mfc + 1) % 4;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end else begin
            mh = 0;
            mv = 0;
        end
        @(posedge clk);
        #1;
        chk("hsync", 64'(hsync), 64'(e_hs));
        chk("vsync", 64'(vsync), 64'(e_vs));
        chk("valid", 64'(valid), 64'(e_val));
        chk("data", data, e_d);
        chk("data_type", 64'(dtype), e_val ? 64'h1E : 64'h0);
        chk("frame_cnt", 64'(fcnt), 64'(mfc));
    endtask

    // Tick until the k-th (0-based) valid word from now and return it.
    task automatic wait_word(input int k, output logic [63:0] d);
        int seen;
        seen = 0;
        d = 'x;
        for (int n = 0; n < 4 * FRAME; n++) begin
            tick();
            if (valid) begin
                if (seen == k) begin
                    d = data;
                    return;
                end
                seen++;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_word timeout k=%0d actual=none required=valid", k);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hsync"}, 64'(hsync), 64'h0);
        chk({tag, "_vsync"}, 64'(vsync), 64'h0);
        chk({tag, "_valid"}, 64'(valid), 64'h0);
        chk({tag, "_data"}, data, 64'h0);
        chk({tag, "_dtype"}, 64'(dtype), 64'h0);
        chk({tag, "_fcnt"}, 64'(fcnt), 64'h0);
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        en   = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        mh = 0; mv = 0; mfc = 0; mpat = 2'd0;
    endtask

    typedef struct {
        logic [1:0]  pat;
        int          y;
        int          x;
        logic [63:0] exp_data;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] w;
    logic [63:0] solid[5];
    int          fc_exp[5];
    logic [63:0] first;
    logic        got;
    logic [1:0]  fc_saved;

    initial begin
        vecs[0] = '{2'd0, 0, 0, 64'h0003_0002_0001_0000};
        vecs[1] = '{2'd0, 0, 1, 64'h0007_0006_0005_0004};
        vecs[2] = '{2'd0, 1, 7, 64'h001F_001E_001D_001C};
        vecs[3] = '{2'd1, 1, 0, 64'h0103_0102_0101_0100};
        vecs[4] = '{2'd1, 1, 5, 64'h0117_0116_0115_0114};
        vecs[5] = '{2'd3, 0, 4, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{2'd3, 0, 3, 64'h0000_0000_0000_0000};
        vecs[7] = '{2'd3, 1, 4, 64'hFFFF_FFFF_FFFF_FFFF};
        solid[0] = 64'h0000_0000_0000_0000;
        solid[1] = 64'h0001_0001_0001_0001;
        solid[2] = 64'h0002_0002_0002_0002;
        solid[3] = 64'h0003_0003_0003_0003;
        solid[4] = 64'h0000_0000_0000_0000;
        fc_exp = '{1, 2, 3, 0, 1};

        reset_dut();
        repeat (3) tick();

        // Table vectors: restart the generator, then pick one word.
        for (int t = 0; t < 8; t++) begin
            en = 1'b0;
            tick();
            sel = vecs[t].pat;
            en  = 1'b1;
            wait_word(vecs[t].y * 8 + vecs[t].x, w);
            chk($sformatf("vec%0d_data", t), w, vecs[t].exp_data);
            chk($sformatf("vec%0d_dtype", t), 64'(dtype), 64'h1E);
        end

        // Solid pattern over 5 frames with a 2-bit frame counter.
        reset_dut();
        sel = 2'd2;
        en  = 1'b1;
        for (int f = 0; f < 5; f++) begin
            got = 1'b0;
            first = 'x;
            for (int n = 0; n < FRAME; n++) begin
                tick();
                if (valid && !got) begin
                    first = data;
                    got = 1'b1;
                end
            end
            chk($sformatf("solid_f%0d", f), first, solid[f]);
            chk($sformatf("fcnt_f%0d", f), 64'(fcnt), 64'(fc_exp[f]));
        end

        // Pattern change mid-line: rest of frame stays ramp, next is checker.
        reset_dut();
        sel = 2'd0;
        en  = 1'b1;
        wait_word(2, w);
        chk("sw_before", w, 64'h000B_000A_0009_0008);
        sel = 2'd3;
        wait_word(0, w);
        chk("sw_still_ramp", w, 64'h000F_000E_000D_000C);
        wait_word(16, w);
        chk("sw_checker", w, 64'hFFFF_FFFF_FFFF_FFFF);

        // Drop run enable mid-active for 3 clocks.
        wait_word(1, w);
        fc_saved = fcnt;
        en = 1'b0;
        repeat (3) tick();
        chk("drop_fcnt_kept", 64'(fcnt), 64'(fc_saved));
        en = 1'b1;
        tick();
        chk("restart_hsync", 64'(hsync), 64'h1);
        chk("restart_vsync", 64'(vsync), 64'h1);
        repeat (FRAME - 1) tick();
        chk("restart_fcnt", 64'(fcnt), 64'((fc_saved + 1) % 4));

        // Asynchronous reset in the middle of a frame.
        repeat (30) tick();
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mh = 0; mv = 0; mfc = 0; mpat = 2'd0;
        repeat (FRAME) tick();
        chk("post_rst_fcnt", 64'(fcnt), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vid_4ppc_tx.md
Name: vid_4ppc_tx

Overview:
Video stream transmitter that generates the 4-pixel-per-clock stream consumed by the frame capture path. It produces hsync, vsync, pixel_valid and data_type timing plus self-generated 64-bit pixel words from selectable test patterns. The block sits at the source end of the pixel-clock domain and drives img_save directly, or any other 4PPC sink. It replaces TB-side memory feeding as the default stimulus source.

Parameters:
HACT, 1920, active pixels per line; must be a multiple of PPC and of 8
VACT, 1080, active lines per frame
HSA, 4, hsync width in clocks
HBP, 4, horizontal back porch in clocks
HFP, 4, horizontal front porch in clocks
VSA, 1, vsync width in lines
VBP, 1, vertical back porch in lines
VFP, 1, vertical front porch in lines
PPC, 4, pixels per clock; fixed at 4
BPP, 16, bits per pixel; PPC*BPP = 64
DATA_TYPE, 6'h1E, data type driven during active words
FCNT_W, 16, frame counter width

Ports:
i_clk  in  1  pixel clock
i_rstn  in  1  async active-low reset
i_init_done  in  1  run enable; 0 holds the generator idle
i_pattern_sel  in  2  test pattern select
o_hsync  out  1  active-high hsync
o_vsync  out  1  active-high vsync
o_pixel_data  out  64  4 pixels; lane i at bits [16i+15:16i], lane 0 = leftmost
o_pixel_valid  out  1  active word strobe
o_data_type  out  6  DATA_TYPE when valid, else 0
o_frame_cnt  out  FCNT_W  completed frame count

Behaviour:
- One clock (i_clk); reset asynchronous active-low (i_rstn). All outputs 0 during reset; counters 0.
- HW = HACT/PPC. HTOT = HSA+HBP+HW+HFP clocks. VTOT = VSA+VBP+VACT+VFP lines.
- h_cnt 0..HTOT-1, increments each clock; at HTOT-1 wraps to 0 and v_cnt increments; v_cnt wraps VTOT-1 -> 0.
- Horizontal order: sync [0,HSA), back porch, active [HSA+HBP, HSA+HBP+HW), front porch. Vertical order: sync [0,VSA), back porch, active [VSA+VBP, VSA+VBP+VACT), front porch.
- hsync = (h_cnt < HSA), asserted on every line, including blanking lines. vsync = (v_cnt < VSA), for whole lines.
- valid = h active AND v active. x = h_cnt-(HSA+HBP) (word index), y = v_cnt-(VSA+VBP).
- All outputs registered; 1 clock latency from counter state to pins. hsync, vsync, valid, data and data_type are aligned on the same cycle.
- Patterns (pixel column px = 4x+i, 16 bits):
  - 0: ramp, pixel = px[15:0].
  - 1: coordinate, pixel = {y[7:0], px[7:0]}.
  - 2: solid, pixel = o_frame_cnt zero-extended/truncated to 16.
  - 3: checker 16x16, pixel = (px[4]^y[4]) ? 16'hFFFF : 16'h0000.
- o_pixel_data is 0 when not valid.
- i_pattern_sel is sampled into a shadow register only when h_cnt==0 and v_cnt==0. A change mid-frame takes effect at the next frame start.
- o_frame_cnt increments when h_cnt==HTOT-1 and v_cnt==VTOT-1, wrapping at all-ones to 0. It is not cleared by i_init_done.
- i_init_done=0: h_cnt and v_cnt are forced to 0, and all timing/data outputs go 0 the next clock. This also applies mid-frame; the partial frame is abandoned and not counted.
- i_init_done 0->1: h_cnt=0, v_cnt=0 on the first enabled clock. The first hsync/vsync appears one clock later. The pattern is sampled at that point.
- Reset mid-frame: immediate return to reset state, including o_frame_cnt=0.

Test Plan:
- HACT=16, VACT=2, H/V timings as default, pattern 0: HTOT=16, VTOT=5 -> per frame 8 valid words (4 per line); line 0 of active region words = 0x0003_0002_0001_0000, 0x0007..0004, ...; hsync high 4 clocks per line; vsync high 16 clocks.
- Same config, pattern 1: second active line first word = 0x0103_0102_0101_0100; data_type = 0x1E only while valid, 0 otherwise.
- Pattern 2 over 3 frames: solid words 0x0000_0000_0000_0000, then 0x0001 in every lane, then 0x0002 in every lane; o_frame_cnt steps at the last clock of each frame.
- Switch i_pattern_sel 0->3 mid-active-line: the rest of the frame stays ramp; the next frame is checker (HACT=32: word 4 = 0xFFFF x4 on line y=0).
- Drop i_init_done for 3 clocks mid-active: valid, hsync and vsync are 0 one clock later; after re-enable, a full frame restarts from vsync and the frame count is unchanged. Assert i_rstn=0 mid-frame: all outputs 0 asynchronously and o_frame_cnt=0.
- FCNT_W=2, run 5 frames: o_frame_cnt sequence 1,2,3,0,1.
